// File: rtl/svf_sc_ctrl_if.sv
// rtl/svf_sc_ctrl_if.sv - config handshake bundle for the SVF switched-capacitor controller
interface svf_sc_ctrl_if #(
  parameter int DIV_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [3:0]       cfg_q;
  logic [1:0]       cfg_sel;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_q,
    output cfg_sel,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_q,
    input  cfg_sel,
    output cfg_ready
  );
endinterface

// File: rtl/svf_sc_ctrl.sv
// rtl/svf_sc_ctrl.sv - SVF sc_clk sequencer/configurator; SVF_FC_GLIDE_EN enables one-step-per-period cutoff glide
module svf_sc_ctrl #(
  parameter int         DIV_W   = 8,
  parameter logic [3:0] RESET_Q = 4'd1
) (
  input  logic         clk,
  input  logic         rst_n,
  svf_sc_ctrl_if.slave cfg,
  output logic         sc_clk,
  output logic         q0,
  output logic         q1,
  output logic         q2,
  output logic         q3,
  output logic         sel0,
  output logic         sel1,
  output logic         sample_stb,
  output logic         running
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [3:0]       q_r;
  logic [1:0]       sel_r;
  logic             ready_r;

  logic             pend_valid;
  logic [DIV_W-1:0] pend_div;
  logic [3:0]       pend_q;
  logic [1:0]       pend_sel;

  logic             xfer;
  logic [DIV_W-1:0] div_next;

  assign xfer          = cfg.cfg_valid && ready_r;
  assign cfg.cfg_ready = ready_r;
  assign {q3, q2, q1, q0} = q_r;
  assign {sel1, sel0}     = sel_r;

  // Divider value that the next apply point loads: a jump, or one step toward the target when gliding
  always_comb begin
    div_next = pend_div;
`ifdef SVF_FC_GLIDE_EN
    // Starting or stopping the clock never glides; only running-to-running changes step
    if (pend_div != '0 && div_act != '0 && pend_div != div_act) begin
      if (pend_div > div_act) div_next = div_act + DIV_W'(1);
      else                    div_next = div_act - DIV_W'(1);
    end
`endif
  end

  // Handshake capture plus the STOP/LOW/HIGH sequencer; settings only move on sc_clk falling edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_STOP;
      cnt        <= '0;
      div_act    <= '0;
      q_r        <= RESET_Q;
      sel_r      <= 2'b11;
      ready_r    <= 1'b1;
      pend_valid <= 1'b0;
      pend_div   <= '0;
      pend_q     <= '0;
      pend_sel   <= '0;
      sc_clk     <= 1'b0;
      sample_stb <= 1'b0;
      running    <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      // ready comes back one cycle after the pending slot empties
      ready_r    <= !xfer && !pend_valid;

      // ready is only high while nothing is pending, so capture never collides with apply
      if (xfer) begin
        pend_valid <= 1'b1;
        pend_div   <= cfg.cfg_div;
        pend_q     <= cfg.cfg_q;
        pend_sel   <= cfg.cfg_sel;
      end

      case (state)
        ST_STOP: begin
          sc_clk  <= 1'b0;
          running <= 1'b0;
          if (pend_valid) begin
            q_r        <= pend_q;
            sel_r      <= pend_sel;
            div_act    <= div_next;
            pend_valid <= 1'b0;
            if (div_next != '0) begin
              state   <= ST_LOW;
              cnt     <= div_next;
              running <= 1'b1;
            end
          end
        end

        ST_LOW: begin
          if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
          end else begin
            sc_clk     <= 1'b1;
            sample_stb <= 1'b1;
            state      <= ST_HIGH;
            cnt        <= div_act;
          end
        end

        ST_HIGH: begin
          if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
          end else begin
            sc_clk <= 1'b0;
            if (pend_valid) begin
              q_r        <= pend_q;
              sel_r      <= pend_sel;
              div_act    <= div_next;
              cnt        <= div_next;
              pend_valid <= (div_next != pend_div);
              if (div_next == '0) begin
                state   <= ST_STOP;
                running <= 1'b0;
              end else begin
                state <= ST_LOW;
              end
            end else begin
              cnt   <= div_act;
              state <= ST_LOW;
            end
          end
        end

        default: begin
          state   <= ST_STOP;
          sc_clk  <= 1'b0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_svf_sc_ctrl.sv
// tb/tb_svf_sc_ctrl.sv - directed self-checking bench for svf_sc_ctrl
module tb_svf_sc_ctrl;
  logic clk;
  logic rst_n;
  logic sc_clk, q0, q1, q2, q3, sel0, sel1, sample_stb, running;
  int   checks;
  int   errors;

  svf_sc_ctrl_if #(.DIV_W(8)) cfg ();

  svf_sc_ctrl #(.DIV_W(8), .RESET_Q(4'd1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (cfg),
    .sc_clk     (sc_clk),
    .q0         (q0),
    .q1         (q1),
    .q2         (q2),
    .q3         (q3),
    .sel0       (sel0),
    .sel1       (sel1),
    .sample_stb (sample_stb),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // count negedges until sc_clk shows the requested level (bounded)
  task automatic wait_sc(input logic level, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sc_clk !== level && n < 64);
  endtask

  task automatic send(input logic [7:0] div, input logic [3:0] q, input logic [1:0] sel);
    int n;
    n = 0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_div   = div;
    cfg.cfg_q     = q;
    cfg.cfg_sel   = sel;
    while (cfg.cfg_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", {31'd0, n < 64}, 32'd1);
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    int cnt_a;
    int cnt_b;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div   = '0;
    cfg.cfg_q     = '0;
    cfg.cfg_sel   = '0;
    repeat (3) @(negedge clk);

    // 1: reset values, then div=3 q=5 sel=LP
    chk("rst_sc_clk", sc_clk, 0);
    chk("rst_q", {q3, q2, q1, q0}, 4'd1);
    chk("rst_sel", {sel1, sel0}, 2'b11);
    chk("rst_ready", cfg.cfg_ready, 1);
    chk("rst_stb", sample_stb, 0);
    chk("rst_running", running, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'd3, 4'd5, 2'b00);
    chk("t1_ready_drop", cfg.cfg_ready, 0);
    @(negedge clk);
    chk("t1_q", {q3, q2, q1, q0}, 4'd5);
    chk("t1_sel", {sel1, sel0}, 2'b00);
    chk("t1_running", running, 1);
    chk("t1_sc_low", sc_clk, 0);
    wait_sc(1'b1, n);
    chk("t1_first_rise", n, 4);
    chk("t1_stb_on_rise", sample_stb, 1);
    wait_sc(1'b0, n);
    chk("t1_high_len", n, 4);
    wait_sc(1'b1, n);
    chk("t1_low_len", n, 4);
    cnt_a = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (sample_stb === 1'b1) cnt_a++;
    end
    chk("t1_stb_per_16", cnt_a, 2);

    // 2: sel change requested mid-HIGH lands exactly on the falling edge
    wait_sc(1'b0, n);
    wait_sc(1'b1, n);
    send(8'd3, 4'd5, 2'b10);
    chk("t2_ready_low", cfg.cfg_ready, 0);
    chk("t2_sel_held", {sel1, sel0}, 2'b00);
    chk("t2_still_high", sc_clk, 1);
    wait_sc(1'b0, n);
    chk("t2_fall_delay", n, 3);
    chk("t2_sel_new", {sel1, sel0}, 2'b10);
    chk("t2_ready_at_fall", cfg.cfg_ready, 0);
    @(negedge clk);
    chk("t2_ready_back", cfg.cfg_ready, 1);

    // 4: held valid while not ready is ignored, captured once ready rises
    cfg.cfg_valid = 1'b1;
    cfg.cfg_div   = 8'd3;
    cfg.cfg_q     = 4'd9;
    cfg.cfg_sel   = 2'b01;
    @(negedge clk);
    cfg.cfg_q     = 4'd12;
    cfg.cfg_sel   = 2'b10;
    chk("t4_ready_low", cfg.cfg_ready, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ({q3, q2, q1, q0} !== 4'd9 && n < 64);
    chk("t4_first_applied", {q3, q2, q1, q0}, 4'd9);
    chk("t4_first_sel", {sel1, sel0}, 2'b01);
    chk("t4_ready_at_apply", cfg.cfg_ready, 0);
    @(negedge clk);
    chk("t4_ready_rise", cfg.cfg_ready, 1);
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
    chk("t4_second_captured", cfg.cfg_ready, 0);
    chk("t4_q_not_yet", {q3, q2, q1, q0}, 4'd9);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ({q3, q2, q1, q0} !== 4'd12 && n < 64);
    chk("t4_second_apply_delay", n, 6);
    chk("t4_second_sel", {sel1, sel0}, 2'b10);

    // 3: div=0 stops the clock after the next falling edge
    send(8'd0, 4'd12, 2'b10);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (running !== 1'b0 && n < 64);
    chk("t3_running_off", running, 0);
    chk("t3_sc_low", sc_clk, 0);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sample_stb === 1'b1) cnt_a++;
      if (sc_clk === 1'b1) cnt_b++;
    end
    chk("t3_no_stb", cnt_a, 0);
    chk("t3_no_sc_high", cnt_b, 0);
    chk("t3_ready", cfg.cfg_ready, 1);

    // 5: reset while sc_clk high with a config pending
    send(8'd3, 4'd5, 2'b00);
    wait_sc(1'b1, n);
    send(8'd3, 4'd7, 2'b01);
    chk("t5_pending", cfg.cfg_ready, 0);
    chk("t5_sc_high", sc_clk, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_sc_clk", sc_clk, 0);
    chk("t5_sel", {sel1, sel0}, 2'b11);
    chk("t5_q", {q3, q2, q1, q0}, 4'd1);
    chk("t5_ready", cfg.cfg_ready, 1);
    chk("t5_running", running, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_b = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sc_clk === 1'b1) cnt_b++;
    end
    chk("t5_pending_lost_q", {q3, q2, q1, q0}, 4'd1);
    chk("t5_pending_lost_sc", cnt_b, 0);

    // 6: div 2 -> 6, glide steps or immediate jump
    send(8'd2, 4'd1, 2'b00);
    wait_sc(1'b1, n);
    wait_sc(1'b0, n);
    chk("t6_high_div2", n, 3);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_div   = 8'd6;
    cfg.cfg_q     = 4'd1;
    cfg.cfg_sel   = 2'b00;
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
    wait_sc(1'b1, n);
    chk("t6_low_div2", n, 2);
    wait_sc(1'b0, n);
    chk("t6_high_before_apply", n, 3);
`ifdef SVF_FC_GLIDE_EN
    for (int k = 1; k <= 4; k++) begin
      wait_sc(1'b1, n);
      chk("t6_glide_low", n, 3 + k);
      chk("t6_glide_ready", cfg.cfg_ready, (k == 4) ? 1 : 0);
      wait_sc(1'b0, n);
      chk("t6_glide_high", n, 3 + k);
    end
`else
    wait_sc(1'b1, n);
    chk("t6_jump_low", n, 7);
    chk("t6_jump_ready", cfg.cfg_ready, 1);
    wait_sc(1'b0, n);
    chk("t6_jump_high", n, 7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
